// File: rtl/rf_pkg.sv
// Shared sizing helper and default geometry for the multi-ported register file.
package rf_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

  // Select width for a file of num_regs entries; never narrower than one bit.
  function automatic int sel_width(input int num_regs);
    return (num_regs < 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write busy bits: set on issue, cleared by a retiring write, wiped by flush.
module rf_scoreboard
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_WR   = 2,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_sel_i,
  input  logic                     issue_en_i,
  input  logic [ADDR_W-1:0]        issue_sel_i,
  input  logic                     flush_i,
  output logic [NUM_REGS-1:0]      busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] wr_hit;

  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_en_i[w] && (int'(wr_sel_i[w*ADDR_W +: ADDR_W]) == r)) begin
          wr_hit[r] = 1'b1;
        end
      end
    end

    // An issue outranks a same-cycle write: the newer producer is still in flight.
    for (int r = 0; r < NUM_REGS; r++) begin
      if (flush_i) begin
        busy_d[r] = 1'b0;
      end else if (issue_en_i && (int'(issue_sel_i) == r)) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit[r]) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end

    if (ZERO_REG) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/rf_multiport.sv
// Multi-ported integer register file with per-port write bypass, optional zero
// register and an integrated pending-write scoreboard for Decode hazard stalls.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  NUM_REGS = DEF_NUM_REGS,
  parameter int  NUM_RD   = 2,
  parameter int  NUM_WR   = 2,
  parameter bit  ZERO_REG = 1'b1,
  localparam int ADDR_W   = sel_width(NUM_REGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_sel_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_sel_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic                     issue_en_i,
  input  logic [ADDR_W-1:0]        issue_sel_i,
  input  logic                     flush_i,
  output logic [NUM_REGS-1:0]      busy_o
);

  typedef logic [ADDR_W-1:0] reg_sel_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // With a power-of-two file every select is a real register.
  localparam bit FULL_RANGE = (NUM_REGS == (1 << ADDR_W));

  logic [NUM_WR-1:0]   wr_en;
  reg_sel_t            wr_sel  [NUM_WR];
  reg_data_t           wr_data [NUM_WR];
  reg_data_t           mem_q   [NUM_REGS];
  reg_data_t           mem_d   [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  // Reset also masks writes so the bypass path cannot leak data while held.
  assign wr_en = wr_en_i & {NUM_WR{rst_n_i}};

  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr_unpack
    assign wr_sel[gi]  = wr_sel_i[gi*ADDR_W +: ADDR_W];
    assign wr_data[gi] = wr_data_i[gi*DATA_W +: DATA_W];
  end

  // Later ports overwrite earlier ones, so the highest-index port wins.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      mem_d[r] = mem_q[r];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (int'(wr_sel[w]) == r)) begin
          mem_d[r] = wr_data[w];
        end
      end
    end
    if (ZERO_REG) begin
      mem_d[0] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    reg_sel_t  sel;
    logic      in_range;
    logic      hit;
    reg_data_t data;

    assign sel = rd_sel_i[gi*ADDR_W +: ADDR_W];

    if (FULL_RANGE) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_partial
      assign in_range = (int'(sel) < NUM_REGS);
    end

    always_comb begin
      data = in_range ? mem_q[sel] : '0;
      hit  = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && in_range && (wr_sel[w] == sel)) begin
          data = wr_data[w];
          hit  = 1'b1;
        end
      end
      if (ZERO_REG && (sel == '0)) begin
        data = '0;
      end
    end

    assign rd_data_o[gi*DATA_W +: DATA_W] = data;
    // A retiring write this cycle makes the bypassed value safe to consume.
    assign rd_busy_o[gi] = in_range & busy[sel] & ~hit;
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .wr_en_i     (wr_en),
    .wr_sel_i    (wr_sel_i),
    .issue_en_i  (issue_en_i & rst_n_i),
    .issue_sel_i (issue_sel_i),
    .flush_i     (flush_i),
    .busy_o      (busy)
  );

  assign busy_o = busy;

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport: default 2R/2W file plus a 4R/1W 16-entry sweep.
module tb_rf_multiport;

  logic clk;
  logic rst_n;

  // Default instance: 32 x 32, 2 read, 2 write, zero register.
  logic [9:0]  a_rd_sel;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_sel;
  logic [63:0] a_wr_data;
  logic        a_issue_en;
  logic [4:0]  a_issue_sel;
  logic        a_flush;
  logic [31:0] a_busy;

  // Sweep instance: 16 x 32, 4 read, 1 write, no zero register.
  logic [15:0]  b_rd_sel;
  logic [127:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic [0:0]   b_wr_en;
  logic [3:0]   b_wr_sel;
  logic [31:0]  b_wr_data;
  logic         b_issue_en;
  logic [3:0]   b_issue_sel;
  logic         b_flush;
  logic [15:0]  b_busy;

  rf_multiport u_dut_a (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .rd_sel_i    (a_rd_sel),
    .rd_data_o   (a_rd_data),
    .rd_busy_o   (a_rd_busy),
    .wr_en_i     (a_wr_en),
    .wr_sel_i    (a_wr_sel),
    .wr_data_i   (a_wr_data),
    .issue_en_i  (a_issue_en),
    .issue_sel_i (a_issue_sel),
    .flush_i     (a_flush),
    .busy_o      (a_busy)
  );

  rf_multiport #(
    .DATA_W   (32),
    .NUM_REGS (16),
    .NUM_RD   (4),
    .NUM_WR   (1),
    .ZERO_REG (1'b0)
  ) u_dut_b (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .rd_sel_i    (b_rd_sel),
    .rd_data_o   (b_rd_data),
    .rd_busy_o   (b_rd_busy),
    .wr_en_i     (b_wr_en),
    .wr_sel_i    (b_wr_sel),
    .wr_data_i   (b_wr_data),
    .issue_en_i  (b_issue_en),
    .issue_sel_i (b_issue_sel),
    .flush_i     (b_flush),
    .busy_o      (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end else begin
      $display("ok   %s value=%h", tag, obs);
    end
  endtask

  function automatic logic [31:0] observe(input int kind, input int idx);
    logic [31:0] v;
    case (kind)
      0:       v = a_rd_data[idx*32 +: 32];
      1:       v = {31'b0, a_rd_busy[idx]};
      2:       v = a_busy;
      3:       v = {31'b0, a_busy[idx]};
      4:       v = b_rd_data[idx*32 +: 32];
      5:       v = {31'b0, b_busy[idx]};
      default: v = {31'b0, b_rd_busy[idx]};
    endcase
    return v;
  endfunction

  task automatic push(input string tag, input int kind, input int idx, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.kind, e.idx), e.exp);
    end
  endtask

  // Inputs are driven just after a rising edge; comb outputs are compared at
  // the falling edge, registered ones one step after the edge that loads them.
  task automatic step();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_wr_en    = '0;
    a_issue_en = 1'b0;
    a_flush    = 1'b0;
    b_wr_en    = '0;
    b_issue_en = 1'b0;
    b_flush    = 1'b0;
  endtask

  task automatic a_wr(input int port, input int sel, input logic [31:0] d);
    a_wr_en[port]           = 1'b1;
    a_wr_sel[port*5 +: 5]   = sel[4:0];
    a_wr_data[port*32 +: 32] = d;
  endtask

  task automatic a_rd(input int s0, input int s1);
    a_rd_sel[4:0] = s0[4:0];
    a_rd_sel[9:5] = s1[4:0];
  endtask

  task automatic a_issue(input int sel);
    a_issue_en  = 1'b1;
    a_issue_sel = sel[4:0];
  endtask

  initial begin
    rst_n       = 1'b0;
    a_rd_sel    = '0;
    a_wr_sel    = '0;
    a_wr_data   = '0;
    a_issue_sel = '0;
    b_rd_sel    = '0;
    b_wr_sel    = '0;
    b_wr_data   = '0;
    b_issue_sel = '0;
    idle();

    // Reset held with writes and issue active: nothing may leak out.
    a_wr(0, 5, 32'hDEAD_BEEF);
    a_wr(1, 5, 32'hDEAD_BEEF);
    a_issue(5);
    a_rd(5, 5);
    b_wr_en     = 1'b1;
    b_wr_sel    = 4'd5;
    b_wr_data   = 32'hDEAD_BEEF;
    b_rd_sel    = {4{4'd5}};
    push("rst_rd0", 0, 0, 32'h0);
    push("rst_rd1", 0, 1, 32'h0);
    push("rst_busy", 2, 0, 32'h0);
    push("rst_rdbusy0", 1, 0, 32'h0);
    push("rst_b_rd0", 4, 0, 32'h0);
    step();
    step();

    idle();
    rst_n = 1'b1;
    a_rd(5, 5);
    push("post_rst_r5", 0, 0, 32'h0);
    step();
    push("post_rst_r5_q", 0, 1, 32'h0);
    push("post_rst_busy", 2, 0, 32'h0);
    step();

    // Two ports hit r3: highest port wins, in bypass and in storage.
    idle();
    a_wr(0, 3, 32'h11);
    a_wr(1, 3, 32'h22);
    a_rd(3, 3);
    push("prio_byp0", 0, 0, 32'h22);
    push("prio_byp1", 0, 1, 32'h22);
    step();

    idle();
    a_rd(3, 3);
    push("prio_store0", 0, 0, 32'h22);
    push("prio_store1", 0, 1, 32'h22);
    step();

    idle();
    a_wr(0, 4, 32'h33);
    a_rd(4, 4);
    push("byp_p0_rd0", 0, 0, 32'h33);
    push("byp_p0_rd1", 0, 1, 32'h33);
    step();

    // Zero register: write and issue must both be ignored.
    idle();
    a_wr(1, 0, 32'hFFFF_FFFF);
    a_issue(0);
    a_rd(0, 0);
    push("zero_byp0", 0, 0, 32'h0);
    push("zero_byp1", 0, 1, 32'h0);
    push("zero_rdbusy", 1, 0, 32'h0);
    step();

    idle();
    a_issue(7);
    a_rd(0, 0);
    push("zero_store", 0, 0, 32'h0);
    push("zero_busy0", 3, 0, 32'h0);
    step();

    idle();
    a_rd(7, 7);
    push("issue_busy7", 3, 7, 32'h1);
    push("issue_rdbusy0", 1, 0, 32'h1);
    push("issue_rdbusy1", 1, 1, 32'h1);
    step();

    idle();
    a_wr(0, 7, 32'h55);
    a_rd(7, 3);
    push("clr_rdbusy0", 1, 0, 32'h0);
    push("clr_byp_r7", 0, 0, 32'h55);
    push("clr_busy7_still", 3, 7, 32'h1);
    push("clr_r3_other", 0, 1, 32'h22);
    step();

    idle();
    a_issue(9);
    a_rd(7, 9);
    push("clr_busy7", 3, 7, 32'h0);
    push("clr_store_r7", 0, 0, 32'h55);
    push("r9_not_yet", 1, 1, 32'h0);
    step();

    // WAW: a write retiring while r9 is re-issued keeps it busy.
    idle();
    a_issue(9);
    a_wr(1, 9, 32'h99);
    a_rd(9, 9);
    push("waw_busy9_pre", 3, 9, 32'h1);
    push("waw_rdbusy0", 1, 0, 32'h0);
    push("waw_byp_r9", 0, 0, 32'h99);
    step();

    idle();
    a_flush = 1'b1;
    a_issue(10);
    a_rd(9, 10);
    push("waw_busy9_hold", 3, 9, 32'h1);
    push("waw_rdbusy_hold", 1, 0, 32'h1);
    push("waw_store_r9", 0, 0, 32'h99);
    step();

    idle();
    a_wr(0, 12, 32'hAA);
    a_wr(1, 13, 32'hBB);
    a_rd(12, 13);
    push("flush_all", 2, 0, 32'h0);
    push("dual_byp12", 0, 0, 32'hAA);
    push("dual_byp13", 0, 1, 32'hBB);
    step();

    idle();
    a_rd(13, 12);
    push("dual_store13", 0, 0, 32'hBB);
    push("dual_store12", 0, 1, 32'hAA);
    step();

    // Sweep instance: r0 is an ordinary register, r15 the top one.
    idle();
    b_wr_en   = 1'b1;
    b_wr_sel  = 4'd0;
    b_wr_data = 32'hA5;
    b_rd_sel  = {4{4'd0}};
    for (int p = 0; p < 4; p++) push($sformatf("b_byp_r0_p%0d", p), 4, p, 32'hA5);
    step();

    idle();
    b_wr_en     = 1'b1;
    b_wr_sel    = 4'd15;
    b_wr_data   = 32'h15F;
    b_issue_en  = 1'b1;
    b_issue_sel = 4'd0;
    b_rd_sel    = {4{4'd0}};
    for (int p = 0; p < 4; p++) push($sformatf("b_store_r0_p%0d", p), 4, p, 32'hA5);
    step();

    idle();
    b_rd_sel = {4'd0, 4'd15, 4'd0, 4'd0};
    push("b_store_r15", 4, 2, 32'h15F);
    push("b_busy0", 5, 0, 32'h1);
    push("b_rdbusy0", 6, 0, 32'h1);
    step();

    // Asynchronous reset between edges clears storage immediately.
    idle();
    a_rd(12, 13);
    b_rd_sel = {4'd0, 4'd15, 4'd0, 4'd0};
    rst_n = 1'b0;
    #1;
    push("async_rst_rd0", 0, 0, 32'h0);
    push("async_rst_rd1", 0, 1, 32'h0);
    push("async_rst_b_r15", 4, 2, 32'h0);
    push("async_rst_b_busy", 5, 0, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
